// File: rtl/bcd_digit_gen.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// feeding the four-digit seven-segment scan stage; digits update only on done.
module bcd_digit_gen #(
    parameter int         BIN_W      = 14,
    parameter int         MAX_VAL    = 9999,
    parameter bit         LZ_BLANK   = 1'b1,
    parameter logic [3:0] BLANK_CODE = 4'd15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0
);

    localparam int               CNT_W = $clog2(BIN_W + 1);
    localparam logic [31:0]      MAX_U = 32'(MAX_VAL);
    localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_VAL);

    typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

    state_t             state;
    logic [BIN_W-1:0]   operand;
    logic [15:0]        acc;
    logic [15:0]        acc_adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;
    logic               over;
    logic               blank3, blank2, blank1;

    assign over = (32'(bin) > MAX_U);

    // Add-3 correction on every nibble in parallel, ahead of the shift.
    always_comb begin
        acc_adj = acc;
        for (int n = 0; n < 4; n++) begin
            if (acc[4*n +: 4] >= 4'd5)
                acc_adj[4*n +: 4] = acc[4*n +: 4] + 4'd3;
        end
    end

    // Blanking ripples down from the thousands digit; ones is never blanked.
    assign blank3 = LZ_BLANK && (acc[15:12] == 4'd0);
    assign blank2 = blank3 && (acc[11:8] == 4'd0);
    assign blank1 = blank2 && (acc[7:4] == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            operand  <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            bcd3     <= 4'd0;
            bcd2     <= 4'd0;
            bcd1     <= 4'd0;
            bcd0     <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        operand  <= over ? MAX_B : bin;
                        ovf_pend <= over;
                        acc      <= '0;
                        cnt      <= CNT_W'(BIN_W);
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc     <= {acc_adj[14:0], operand[BIN_W-1]};
                    operand <= operand << 1;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= FINISH;
                end
                FINISH: begin
                    bcd3  <= blank3 ? BLANK_CODE : acc[15:12];
                    bcd2  <= blank2 ? BLANK_CODE : acc[11:8];
                    bcd1  <= blank1 ? BLANK_CODE : acc[7:4];
                    bcd0  <= acc[3:0];
                    ovf   <= ovf_pend;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_digit_gen.sv
// Bench for bcd_digit_gen: decimal reference model with a per-cycle compare,
// directed conversions with literal expectations, then randomized traffic.
module tb_bcd_digit_gen;

    localparam int BIN_W = 14;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy, done, ovf;
    logic [3:0]       bcd3, bcd2, bcd1, bcd0;
    logic             nb_busy, nb_done, nb_ovf;
    logic [3:0]       nb3, nb2, nb1, nb0;

    int checks   = 0;
    int failures = 0;

    bcd_digit_gen #(.BIN_W(BIN_W), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy), .done(done), .ovf(ovf),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0)
    );

    bcd_digit_gen #(.BIN_W(BIN_W), .LZ_BLANK(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(nb_busy), .done(nb_done), .ovf(nb_ovf),
        .bcd3(nb3), .bcd2(nb2), .bcd1(nb1), .bcd0(nb0)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Decimal digits of the saturated value, with optional leading-zero blanking.
    function automatic logic [15:0] digits_of(input int v, input bit lz);
        int         s;
        logic [3:0] d [4];
        bit         blank;
        s = (v > 9999) ? 9999 : v;
        d[3] = 4'(s / 1000);
        d[2] = 4'((s / 100) % 10);
        d[1] = 4'((s / 10) % 10);
        d[0] = 4'(s % 10);
        blank = lz;
        for (int k = 3; k >= 1; k--) begin
            if (blank && d[k] == 4'd0) d[k] = 4'd15;
            else blank = 1'b0;
        end
        return {d[3], d[2], d[1], d[0]};
    endfunction

    // Reference model: a conversion accepted when idle finishes BIN_W+1 edges later.
    int          m_cnt = 0;
    int          m_val = 0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
    logic [15:0] m_dig = 16'h0, m_dig_nb = 16'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    <= 0;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_ovf    <= 1'b0;
            m_dig    <= 16'h0;
            m_dig_nb <= 16'h0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy   <= 1'b0;
                    m_done   <= 1'b1;
                    m_ovf    <= (m_val > 9999);
                    m_dig    <= digits_of(m_val, 1'b1);
                    m_dig_nb <= digits_of(m_val, 1'b0);
                end
            end else if (start) begin
                m_cnt  <= BIN_W + 1;
                m_busy <= 1'b1;
                m_val  <= int'(bin);
            end
        end
    end

    // scoreboard: every cycle both instances are compared against the model
    always @(negedge clk) begin
        checks++;
        if ({busy, done, ovf, bcd3, bcd2, bcd1, bcd0} !== {m_busy, m_done, m_ovf, m_dig}) begin
            failures++;
            $display("FAIL cycle_lz t=%0t actual busy/done/ovf=%b%b%b dig=%h%h%h%h required %b%b%b dig=%h",
                     $time, busy, done, ovf, bcd3, bcd2, bcd1, bcd0, m_busy, m_done, m_ovf, m_dig);
        end
        checks++;
        if ({nb_busy, nb_done, nb_ovf, nb3, nb2, nb1, nb0} !== {m_busy, m_done, m_ovf, m_dig_nb}) begin
            failures++;
            $display("FAIL cycle_nb t=%0t actual busy/done/ovf=%b%b%b dig=%h%h%h%h required %b%b%b dig=%h",
                     $time, nb_busy, nb_done, nb_ovf, nb3, nb2, nb1, nb0, m_busy, m_done, m_ovf, m_dig_nb);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver: one conversion from a negedge; returns at the negedge where done is seen
    task automatic run_conv(input logic [BIN_W-1:0] v, input logic [15:0] exp_d,
                            input logic [15:0] exp_nb, input logic exp_ovf,
                            input string name, input bit repulse);
        int lat, busy_n;
        bit seen;
        start = 1'b1; bin = v; lat = 0; busy_n = 0; seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (repulse && i == 5) begin start = 1'b1; bin = 14'd5555; end
            if (repulse && i == 6) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = i - 1;
            end else if (busy) begin
                busy_n++;
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_latency"}, 32'(lat), 32'd15);
        chk({name, "_busy_cycles"}, 32'(busy_n), 32'd15);
        chk({name, "_digits"}, {16'h0, bcd3, bcd2, bcd1, bcd0}, {16'h0, exp_d});
        chk({name, "_digits_nb"}, {16'h0, nb3, nb2, nb1, nb0}, {16'h0, exp_nb});
        chk({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    endtask

    initial begin
        int d_at [3];
        int nd;
        rst_n = 1'b1; start = 1'b0; bin = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_async", {23'h0, busy, done, ovf, bcd3, bcd2, bcd1, bcd0}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_conv(14'd1234,  16'h1234, 16'h1234, 1'b0, "c1234", 1'b0);
        run_conv(14'd7,     16'hFFF7, 16'h0007, 1'b0, "c7", 1'b0);
        run_conv(14'd0,     16'hFFF0, 16'h0000, 1'b0, "c0", 1'b0);
        run_conv(14'd1005,  16'h1005, 16'h1005, 1'b0, "c1005", 1'b0);
        run_conv(14'd9999,  16'h9999, 16'h9999, 1'b0, "c9999", 1'b0);
        run_conv(14'd12000, 16'h9999, 16'h9999, 1'b1, "c12000", 1'b0);
        run_conv(14'd42,    16'hFF42, 16'h0042, 1'b0, "c42", 1'b0);
        run_conv(14'd1234,  16'h1234, 16'h1234, 1'b0, "repulse", 1'b1);

        // start held high: done pulses must be 16 cycles apart
        start = 1'b1; bin = 14'd1234; nd = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (done && nd < 3) begin d_at[nd] = i; nd++; end
        end
        start = 1'b0;
        chk("held_pulses", 32'(nd), 32'd3);
        chk("held_first", 32'(d_at[0]), 32'd16);
        chk("held_gap1", 32'(d_at[1] - d_at[0]), 32'd16);
        chk("held_gap2", 32'(d_at[2] - d_at[1]), 32'd16);
        repeat (20) @(negedge clk);

        run_conv(14'd42, 16'hFF42, 16'h0042, 1'b0, "pre_rst", 1'b0);
        // reset asserted between edges mid-conversion
        start = 1'b1; bin = 14'd4321;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid", {23'h0, busy, done, ovf, bcd3, bcd2, bcd1, bcd0}, 32'h0);
        @(negedge clk);
        chk("reset_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_conv(14'd4321, 16'h4321, 16'h4321, 1'b0, "c4321", 1'b0);

        // randomized traffic, including starts while busy
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
                case ($urandom_range(0, 3))
                    0: bin = 14'($urandom_range(0, 16383));
                    1: bin = 14'($urandom_range(9990, 10010));
                    2: bin = 14'($urandom_range(0, 99));
                    default: bin = 14'($urandom_range(0, 9999));
                endcase
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
